// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// datapath mux select codes, and the opcode/funct values it decodes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_WB_R      = 4'd3,
    S_EXEC_I    = 4'd4,
    S_WB_I      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [2:0] SRCB_REG     = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_IMM     = 3'b010;
  localparam logic [2:0] SRCB_IMM_SH2 = 3'b011;
  localparam logic [2:0] SRCB_SHAMT   = 3'b100;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_OPCODE = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  // Constant-shift R-types take the shift amount from the instruction, not from rs.
  function automatic logic is_shamt_shift(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Counts cycles spent in a memory-access state; done marks the final
// cycle of a MEM_WAIT+1 cycle hold.
module ctrl_wait_counter #(
  parameter int WAIT_W   = 4,
  parameter int MEM_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [WAIT_W-1:0] count,
  output logic              done
);

  logic [WAIT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign done  = (r_count == WAIT_W'(MEM_WAIT));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath selects and write enables from the current state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int WAIT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op_code,
  input  logic [5:0] Funct,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       halted
);

  state_t            r_state;
  state_t            w_next;
  logic              w_clear;
  logic              w_cnt_en;
  logic              w_done;
  logic [WAIT_W-1:0] w_count;

  assign w_cnt_en = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                    (r_state == S_MEM_WRITE);
  assign w_clear  = (w_next != r_state);

  ctrl_wait_counter #(
    .WAIT_W   (WAIT_W),
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .enable (w_cnt_en),
    .count  (w_count),
    .done   (w_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_next = w_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op_code)
          OP_RTYPE:                                 w_next = S_EXEC_R;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: w_next = S_EXEC_I;
          OP_LW, OP_SW:                             w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                           w_next = S_BRANCH;
          OP_J:                                     w_next = S_JUMP;
          default:                                  w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:    w_next = S_WB_R;
      S_WB_R:      w_next = S_FETCH;
      S_EXEC_I:    w_next = S_WB_I;
      S_WB_I:      w_next = S_FETCH;
      S_MEM_ADDR:  w_next = (Op_code == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next = w_done ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = w_done ? S_FETCH : S_MEM_WRITE;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_ILLEGAL:   w_next = S_ILLEGAL;
      default:     w_next = S_FETCH;
    endcase
  end

  always_comb begin
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB = SRCB_FOUR;
        IRWrite = w_done;
        PCWrite = w_done;
      end
      S_DECODE:    ALUSrcB = SRCB_IMM_SH2;
      S_EXEC_R: begin
        ALUOp = ALUOP_FUNCT;
        if (is_shamt_shift(Funct)) begin
          ALUSrcA = SRCA_SHAMT;
          ALUSrcB = SRCB_SHAMT;
        end else begin
          ALUSrcA = SRCA_REG;
          ALUSrcB = SRCB_REG;
        end
      end
      S_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_OPCODE;
      end
      S_WB_I:      RegWrite = 1'b1;
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ:  IorD = 1'b1;
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = SRCA_REG;
        ALUOp       = ALUOP_SUB;
        PCSource    = PCSRC_ALUOUT;
        PCWriteCond = 1'b1;
        BranchNe    = (Op_code == OP_BNE);
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      S_ILLEGAL:   halted = 1'b1;
      default: ;
    endcase
    // Reset leaves the state at FETCH, whose final cycle would otherwise pulse IRWrite/PCWrite.
    if (rst) begin
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      PCWriteCond = 1'b0;
      halted      = 1'b0;
    end
  end

  a_wait_in_range: assert property (@(posedge clk) disable iff (rst)
    w_count <= WAIT_W'(MEM_WAIT));

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: three instances (MEM_WAIT 0, 2, 3)
// with every control output compared per cycle against hand-built vectors.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       halted;
    logic       BranchNe;
    logic       PCWriteCond;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic [2:0] ALUSrcB;
    logic [1:0] ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       MemWrite;
    logic       IRWrite;
    logic       IorD;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1;
  logic       rst2 = 1'b1;
  logic       rst3 = 1'b1;
  logic [5:0] op = 6'h00;
  logic [5:0] fn = 6'h00;
  ctl_t       c0, c2, c3;
  int         checks = 0;
  int         errors = 0;

  ctl_t E_FW, E_FL, E_DEC, E_EXR, E_EXRS, E_WBR, E_EXI, E_WBI;
  ctl_t E_MA, E_MR, E_MWB, E_MW, E_BRNE, E_BREQ, E_JMP, E_ILL;

  mips_multicycle_ctrl #(.MEM_WAIT(0), .WAIT_W(4)) u0 (
    .clk(clk), .rst(rst0), .Op_code(op), .Funct(fn),
    .IorD(c0.IorD), .IRWrite(c0.IRWrite), .MemWrite(c0.MemWrite),
    .MemtoReg(c0.MemtoReg), .RegDst(c0.RegDst), .RegWrite(c0.RegWrite),
    .ALUSrcA(c0.ALUSrcA), .ALUSrcB(c0.ALUSrcB), .ALUOp(c0.ALUOp),
    .PCSource(c0.PCSource), .PCWrite(c0.PCWrite), .PCWriteCond(c0.PCWriteCond),
    .BranchNe(c0.BranchNe), .halted(c0.halted)
  );

  mips_multicycle_ctrl #(.MEM_WAIT(2), .WAIT_W(4)) u2 (
    .clk(clk), .rst(rst2), .Op_code(op), .Funct(fn),
    .IorD(c2.IorD), .IRWrite(c2.IRWrite), .MemWrite(c2.MemWrite),
    .MemtoReg(c2.MemtoReg), .RegDst(c2.RegDst), .RegWrite(c2.RegWrite),
    .ALUSrcA(c2.ALUSrcA), .ALUSrcB(c2.ALUSrcB), .ALUOp(c2.ALUOp),
    .PCSource(c2.PCSource), .PCWrite(c2.PCWrite), .PCWriteCond(c2.PCWriteCond),
    .BranchNe(c2.BranchNe), .halted(c2.halted)
  );

  mips_multicycle_ctrl #(.MEM_WAIT(3), .WAIT_W(4)) u3 (
    .clk(clk), .rst(rst3), .Op_code(op), .Funct(fn),
    .IorD(c3.IorD), .IRWrite(c3.IRWrite), .MemWrite(c3.MemWrite),
    .MemtoReg(c3.MemtoReg), .RegDst(c3.RegDst), .RegWrite(c3.RegWrite),
    .ALUSrcA(c3.ALUSrcA), .ALUSrcB(c3.ALUSrcB), .ALUOp(c3.ALUOp),
    .PCSource(c3.PCSource), .PCWrite(c3.PCWrite), .PCWriteCond(c3.PCWriteCond),
    .BranchNe(c3.BranchNe), .halted(c3.halted)
  );

  task automatic build_vectors();
    E_FW = '0;  E_FW.ALUSrcB = 3'b001;
    E_FL = E_FW; E_FL.IRWrite = 1'b1; E_FL.PCWrite = 1'b1;
    E_DEC = '0; E_DEC.ALUSrcB = 3'b011;
    E_EXR = '0; E_EXR.ALUSrcA = 2'b01; E_EXR.ALUOp = 2'b10;
    E_EXRS = '0; E_EXRS.ALUSrcA = 2'b10; E_EXRS.ALUSrcB = 3'b100; E_EXRS.ALUOp = 2'b10;
    E_WBR = '0; E_WBR.RegDst = 1'b1; E_WBR.RegWrite = 1'b1;
    E_EXI = '0; E_EXI.ALUSrcA = 2'b01; E_EXI.ALUSrcB = 3'b010; E_EXI.ALUOp = 2'b11;
    E_WBI = '0; E_WBI.RegWrite = 1'b1;
    E_MA = '0;  E_MA.ALUSrcA = 2'b01; E_MA.ALUSrcB = 3'b010;
    E_MR = '0;  E_MR.IorD = 1'b1;
    E_MWB = '0; E_MWB.MemtoReg = 1'b1; E_MWB.RegWrite = 1'b1;
    E_MW = '0;  E_MW.IorD = 1'b1; E_MW.MemWrite = 1'b1;
    E_BREQ = '0; E_BREQ.ALUSrcA = 2'b01; E_BREQ.ALUOp = 2'b01;
    E_BREQ.PCSource = 2'b01; E_BREQ.PCWriteCond = 1'b1;
    E_BRNE = E_BREQ; E_BRNE.BranchNe = 1'b1;
    E_JMP = '0; E_JMP.PCSource = 2'b10; E_JMP.PCWrite = 1'b1;
    E_ILL = '0; E_ILL.halted = 1'b1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (c0 !== E_FW) begin errors++; $display("FAIL reset_w0: got %h expected %h", c0, E_FW); end
    checks++;
    if (c2 !== E_FW) begin errors++; $display("FAIL reset_w2: got %h expected %h", c2, E_FW); end
    checks++;
    if (c3 !== E_FW) begin errors++; $display("FAIL reset_w3: got %h expected %h", c3, E_FW); end
  endtask

  task automatic test_rtype();
    ctl_t exp[5];
    exp = '{E_FL, E_DEC, E_EXR, E_WBR, E_FL};
    rst0 = 1'b1; op = 6'h00; fn = 6'h20;
    @(posedge clk); @(negedge clk); rst0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (c0 !== exp[i]) begin errors++; $display("FAIL rtype_add cycle %0d: got %h expected %h", i + 1, c0, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_shift();
    ctl_t exp[5];
    exp = '{E_FL, E_DEC, E_EXRS, E_WBR, E_FL};
    rst0 = 1'b1; op = 6'h00; fn = 6'h00;
    @(posedge clk); @(negedge clk); rst0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (c0 !== exp[i]) begin errors++; $display("FAIL shift_sll cycle %0d: got %h expected %h", i + 1, c0, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_immediate();
    ctl_t exp[5];
    exp = '{E_FL, E_DEC, E_EXI, E_WBI, E_FL};
    rst0 = 1'b1; op = 6'h0D; fn = 6'h00;
    @(posedge clk); @(negedge clk); rst0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (c0 !== exp[i]) begin errors++; $display("FAIL imm_ori cycle %0d: got %h expected %h", i + 1, c0, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    ctl_t exp[12];
    exp = '{E_FW, E_FW, E_FW, E_FL, E_DEC, E_MA, E_MR, E_MR, E_MR, E_MR, E_MWB, E_FW};
    rst3 = 1'b1; op = 6'h23; fn = 6'h00;
    @(posedge clk); @(negedge clk); rst3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1; checks++;
      if (c3 !== exp[i]) begin errors++; $display("FAIL load_w3 cycle %0d: got %h expected %h", i + 1, c3, exp[i]); end
      @(negedge clk);
    end
    rst3 = 1'b1;
  endtask

  task automatic test_store_wait();
    ctl_t exp[9];
    exp = '{E_FW, E_FW, E_FL, E_DEC, E_MA, E_MW, E_MW, E_MW, E_FW};
    rst2 = 1'b1; op = 6'h2B; fn = 6'h00;
    @(posedge clk); @(negedge clk); rst2 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1; checks++;
      if (c2 !== exp[i]) begin errors++; $display("FAIL store_w2 cycle %0d: got %h expected %h", i + 1, c2, exp[i]); end
      @(negedge clk);
    end
    rst2 = 1'b1;
  endtask

  task automatic test_branch();
    ctl_t exp[4];
    for (int k = 0; k < 2; k++) begin
      op   = (k == 0) ? 6'h05 : 6'h04;
      exp  = '{E_FL, E_DEC, ((k == 0) ? E_BRNE : E_BREQ), E_FL};
      rst0 = 1'b1;
      @(posedge clk); @(negedge clk); rst0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        #1; checks++;
        if (c0 !== exp[i]) begin errors++; $display("FAIL branch op=%h cycle %0d: got %h expected %h", op, i + 1, c0, exp[i]); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jump();
    ctl_t exp[4];
    exp = '{E_FL, E_DEC, E_JMP, E_FL};
    rst0 = 1'b1; op = 6'h02;
    @(posedge clk); @(negedge clk); rst0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (c0 !== exp[i]) begin errors++; $display("FAIL jump cycle %0d: got %h expected %h", i + 1, c0, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    ctl_t exp[10];
    exp = '{E_FL, E_DEC, E_ILL, E_ILL, E_ILL, E_ILL, E_ILL, E_ILL, E_ILL, E_ILL};
    rst0 = 1'b1; op = 6'h3F;
    @(posedge clk); @(negedge clk); rst0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1; checks++;
      if (c0 !== exp[i]) begin errors++; $display("FAIL illegal cycle %0d: got %h expected %h", i + 1, c0, exp[i]); end
      if (i == 4) op = 6'h00;
      @(negedge clk);
    end
    #1 rst0 = 1'b1;
    #1; checks++;
    if (c0 !== E_FW) begin errors++; $display("FAIL illegal_reset: got %h expected %h", c0, E_FW); end
    @(negedge clk); rst0 = 1'b0;
    #1; checks++;
    if (c0 !== E_FL) begin errors++; $display("FAIL illegal_release: got %h expected %h", c0, E_FL); end
  endtask

  task automatic test_reset_mid_read();
    ctl_t exp[5];
    exp = '{E_FW, E_FW, E_FW, E_FL, E_DEC};
    rst3 = 1'b1; op = 6'h23;
    @(posedge clk); @(negedge clk); rst3 = 1'b0;
    repeat (6) @(negedge clk);
    #1; checks++;
    if (c3 !== E_MR) begin errors++; $display("FAIL midread_enter: got %h expected %h", c3, E_MR); end
    #2 rst3 = 1'b1;
    #1; checks++;
    if (c3 !== E_FW) begin errors++; $display("FAIL midread_async: got %h expected %h", c3, E_FW); end
    @(negedge clk); #1; checks++;
    if (c3 !== E_FW) begin errors++; $display("FAIL midread_held: got %h expected %h", c3, E_FW); end
    @(negedge clk); rst3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (c3 !== exp[i]) begin errors++; $display("FAIL midread_refetch cycle %0d: got %h expected %h", i + 1, c3, exp[i]); end
      @(negedge clk);
    end
    rst3 = 1'b1;
  endtask

  task automatic test_back_to_back();
    ctl_t exp[8];
    exp = '{E_FL, E_DEC, E_EXR, E_WBR, E_FL, E_DEC, E_JMP, E_FL};
    rst0 = 1'b1; op = 6'h00; fn = 6'h22;
    @(posedge clk); @(negedge clk); rst0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1; checks++;
      if (c0 !== exp[i]) begin errors++; $display("FAIL back_to_back cycle %0d: got %h expected %h", i + 1, c0, exp[i]); end
      if (i == 4) op = 6'h02;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    build_vectors();
    test_reset();
    test_rtype();
    test_shift();
    test_immediate();
    test_load_wait();
    test_store_wait();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_mid_read();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Parametrised multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback for R-type, ALU-immediate, LW/SW, BEQ/BNE and J. It extends the existing control module with load/store, branch and jump support, plus a configurable fixed memory latency. It sits between the instruction register (`Op_code`/`Funct`) and the datapath mux selects and write enables.

## Interface

**Parameters**

- `MEM_WAIT`, default 0: extra wait cycles per memory access, legal range 0..15.
- `WAIT_W`, default 4: width of the wait counter; must satisfy 2^WAIT_W > MEM_WAIT.

**Ports**

- One clock; reset is asynchronous and active-high.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `Op_code` in 6: instruction opcode field from the IR.
- `Funct` in 6: instruction funct field from the IR.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: instruction register write enable.
- `MemWrite` out 1: data memory write enable.
- `MemtoReg` out 1: register write data select; 1 = memory data register, 0 = ALUOut.
- `RegDst` out 1: destination register select; 1 = rd, 0 = rt.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 2: ALU A select; 00 = PC, 01 = A, 10 = shamt path.
- `ALUSrcB` out 3: ALU B select; 000 = B, 001 = const 4, 010 = sign-extended imm, 011 = imm<<2, 100 = shamt.
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = funct-decoded, 11 = opcode-decoded.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `PCWrite` out 1: unconditional PC write enable.
- `PCWriteCond` out 1: conditional PC write (branch).
- `BranchNe` out 1: invert the zero test; high for BNE.
- `halted` out 1: high in the ILLEGAL state.

## Operation

- **Output style.** Moore outputs, decoded combinationally from `state` (and `Funct` in EXEC_R). Every output not listed for a state is 0.
- **FETCH.** IorD=0, ALUSrcA=00, ALUSrcB=001, ALUOp=00, PCSource=00. The state is held for MEM_WAIT+1 cycles. IRWrite=1 and PCWrite=1 only on the final cycle, so PC advances exactly once per fetch. Next: DECODE.
- **DECODE.** ALUSrcB=011, ALUOp=00 (branch target into ALUOut). Next state by `Op_code`:
  - RTYPE(0x00) → EXEC_R
  - ADDI/SLTI/ANDI/ORI/XORI (0x08/0x0A/0x0C/0x0D/0x0E) → EXEC_I
  - LW(0x23), SW(0x2B) → MEM_ADDR
  - BEQ(0x04), BNE(0x05) → BRANCH
  - J(0x02) → JUMP
  - anything else → ILLEGAL
- **EXEC_R.** ALUOp=10. If Funct is SLL(0x00), SRL(0x02) or SRA(0x03): ALUSrcA=10, ALUSrcB=100. Otherwise ALUSrcA=01, ALUSrcB=000. Next: WB_R.
- **WB_R.** RegDst=1, RegWrite=1. Next: FETCH.
- **EXEC_I.** ALUSrcA=01, ALUSrcB=010, ALUOp=11. Next: WB_I.
- **WB_I.** RegDst=0, RegWrite=1. Next: FETCH.
- **MEM_ADDR.** ALUSrcA=01, ALUSrcB=010, ALUOp=00. Next: MEM_READ for LW, MEM_WRITE for SW.
- **MEM_READ.** IorD=1, held MEM_WAIT+1 cycles. Next: MEM_WB.
- **MEM_WB.** MemtoReg=1, RegDst=0, RegWrite=1. Next: FETCH.
- **MEM_WRITE.** IorD=1, MemWrite=1 on every cycle of the MEM_WAIT+1 hold. Next: FETCH.
- **BRANCH.** ALUSrcA=01, ALUSrcB=000, ALUOp=01, PCSource=01, PCWriteCond=1. BranchNe=1 if Op_code==0x05. Next: FETCH.
- **JUMP.** PCSource=10, PCWrite=1. Next: FETCH.
- **ILLEGAL.** halted=1, all enables 0. The FSM stays here until `rst`.
- **Undefined encodings.** Any undefined state encoding goes to FETCH on the next clock.

## Timing

- **Wait counter.** `wait_cnt` is cleared on every state change. It increments while in FETCH, MEM_READ or MEM_WRITE. The final cycle is `wait_cnt == MEM_WAIT`.
- **Cycles per instruction (W = MEM_WAIT):**
  - R-type and ALU-immediate: W+4
  - LW: 2W+5
  - SW: 2W+4
  - BEQ/BNE and J: W+3
- **Reset.**
  - `rst` high at any time, including mid-wait: state=FETCH, wait_cnt=0 immediately.
  - While `rst` is high, IRWrite, PCWrite, MemWrite, RegWrite, PCWriteCond and halted are forced to 0. Mux selects show their FETCH values.
  - The first fetch cycle counts from the first rising edge after `rst` falls.
- **Input sampling.** `Op_code`/`Funct` are sampled only in DECODE, EXEC_R, MEM_ADDR and BRANCH. They are ignored elsewhere, since the IR changes during FETCH.

## Structure

- **Package `mips_ctrl_pkg`** holds:
  - the state encoding (4-bit), with FETCH = 0;
  - the ALUSrcA/ALUSrcB/ALUOp/PCSource select constants.
- **Shared headers.** Opcode and funct values come from the existing `mips_op_codes_defines.v` and `mips_funct_defines.v`.
- **Sub-module `ctrl_wait_counter`.** Parameter WAIT_W; inputs clear, enable; outputs count and done. Instantiated once.

## Test plan

- **R-type.** MEM_WAIT=0, ADD (op 0x00, funct 0x20) → states FETCH, DECODE, EXEC_R, WB_R; RegWrite=1 and RegDst=1 in cycle 4; back to FETCH in cycle 5.
- **Shift.** SLL (funct 0x00) → in EXEC_R, ALUSrcA=10 and ALUSrcB=100.
- **Load with wait states.** MEM_WAIT=3, LW → 11 cycles total; IRWrite/PCWrite high only in cycle 4; MemtoReg=1 and RegWrite=1 in cycle 11.
- **Store.** MEM_WAIT=2, SW → MemWrite high for exactly 3 consecutive cycles with IorD=1; RegWrite never asserted.
- **Branch and jump.** BNE → BRANCH with PCWriteCond=1, BranchNe=1, PCSource=01. J → PCWrite=1 with PCSource=10.
- **Illegal opcode and reset.** Op 0x3F → halted=1 held indefinitely. `rst` pulsed mid-MEM_READ → immediate FETCH with all enables 0, then a normal fetch after release.
